// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizes for the cacheline <-> burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BURST_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned BEAT_IDX_W  = $clog2(BEATS);
  localparam int unsigned TMO_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Line viewed as beats; index 0 is line bits [63:0].
  typedef logic [BEATS-1:0][BURST_WIDTH-1:0] line_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: one 256-bit arbiter transaction <-> four 64-bit memory beats.
// Optional watchdog: define CACHELINE_ADAPTOR_TIMEOUT_EN to add err_o and
// parameter TIMEOUT_CYCLES; a stalled burst is then completed with an error.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  ,
  output logic                   err_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  state_e                state;
  logic [BEAT_IDX_W-1:0] cnt;
  line_t                 rd_line;
  line_t                 wr_line;

  // Read data is its own register so a write never disturbs line_o.
  assign line_o  = rd_line;
  assign burst_o = wr_line[cnt];

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = !resp_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Stall watchdog: counts consecutive beat-less cycles inside a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (resp_i || (state != READ && state != WRITE)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`endif

  // Transaction FSM with beat counter, line buffers and registered handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_line   <= '0;
      wr_line   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      err_o     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          if (write_i) begin
            state     <= WRITE;
            write_o   <= 1'b1;
            wr_line   <= line_i;
            address_o <= address_i & LINE_MASK;
            cnt       <= '0;
          end else if (read_i) begin
            state     <= READ;
            read_o    <= 1'b1;
            address_o <= address_i & LINE_MASK;
            cnt       <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            rd_line[cnt] <= burst_i;
            cnt          <= cnt + BEAT_IDX_W'(1);
            if (cnt == LAST_BEAT) begin
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
            end
          end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          else if (tmo_hit) begin
            state  <= DONE;
            read_o <= 1'b0;
            resp_o <= 1'b1;
            err_o  <= 1'b1;
          end
`endif
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + BEAT_IDX_W'(1);
            if (cnt == LAST_BEAT) begin
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end
          end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          else if (tmo_hit) begin
            state   <= DONE;
            write_o <= 1'b0;
            resp_o  <= 1'b1;
            err_o   <= 1'b1;
          end
`endif
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed, table-driven bench for cacheline_adaptor (default build).
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus and the outputs expected after its rising edge.
  typedef struct {
    logic                   rst;
    logic                   rd;
    logic                   wr;
    logic                   rsp;
    logic [BURST_WIDTH-1:0] bi;
    logic [ADDR_WIDTH-1:0]  ai;
    logic [LINE_WIDTH-1:0]  li;
    logic                   ro;
    logic                   wo;
    logic                   rso;
    logic [ADDR_WIDTH-1:0]  ea;
    logic                   cbo;
    logic [BURST_WIDTH-1:0] ebo;
    logic                   cl;
    logic [LINE_WIDTH-1:0]  el;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(
    input logic rs, input logic rd, input logic wr, input logic rsp,
    input logic [BURST_WIDTH-1:0] bi, input logic [ADDR_WIDTH-1:0] ai,
    input logic [LINE_WIDTH-1:0] li,
    input logic ro, input logic wo, input logic rso, input logic [ADDR_WIDTH-1:0] ea,
    input logic cbo, input logic [BURST_WIDTH-1:0] ebo,
    input logic cl, input logic [LINE_WIDTH-1:0] el);
    vec_t v;
    v.rst = rs; v.rd = rd; v.wr = wr; v.rsp = rsp; v.bi = bi; v.ai = ai; v.li = li;
    v.ro = ro; v.wo = wo; v.rso = rso; v.ea = ea;
    v.cbo = cbo; v.ebo = ebo; v.cl = cl; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [LINE_WIDTH-1:0] act, input logic [LINE_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  localparam logic [BURST_WIDTH-1:0] B1 = {16{4'h1}};
  localparam logic [BURST_WIDTH-1:0] B2 = {16{4'h2}};
  localparam logic [BURST_WIDTH-1:0] B3 = {16{4'h3}};
  localparam logic [BURST_WIDTH-1:0] B4 = {16{4'h4}};
  localparam logic [BURST_WIDTH-1:0] B5 = {16{4'h5}};
  localparam logic [BURST_WIDTH-1:0] B6 = {16{4'h6}};
  localparam logic [BURST_WIDTH-1:0] B7 = {16{4'h7}};
  localparam logic [BURST_WIDTH-1:0] B8 = {16{4'h8}};
  localparam logic [BURST_WIDTH-1:0] B9 = {16{4'h9}};
  localparam logic [BURST_WIDTH-1:0] BA = {16{4'hA}};
  localparam logic [BURST_WIDTH-1:0] BB = {16{4'hB}};
  localparam logic [BURST_WIDTH-1:0] BC = {16{4'hC}};
  localparam logic [BURST_WIDTH-1:0] D0 = 64'hD000_0000_0000_00D0;
  localparam logic [BURST_WIDTH-1:0] D1 = 64'hD111_1111_1111_11D1;
  localparam logic [BURST_WIDTH-1:0] D2 = 64'hD222_2222_2222_22D2;
  localparam logic [BURST_WIDTH-1:0] D3 = 64'hD333_3333_3333_33D3;
  localparam logic [BURST_WIDTH-1:0] E0 = 64'hE0E0_0000_1111_0E0E;
  localparam logic [BURST_WIDTH-1:0] E1 = 64'hE1E1_2222_3333_1E1E;
  localparam logic [BURST_WIDTH-1:0] E2 = 64'hE2E2_4444_5555_2E2E;
  localparam logic [BURST_WIDTH-1:0] E3 = 64'hE3E3_6666_7777_3E3E;

  localparam logic [LINE_WIDTH-1:0] LR1 = {B4, B3, B2, B1};
  localparam logic [LINE_WIDTH-1:0] LRF = {B8, B7, B6, B5};
  localparam logic [LINE_WIDTH-1:0] LRB = {BC, BB, BA, B9};
  localparam logic [LINE_WIDTH-1:0] LW  = {D3, D2, D1, D0};
  localparam logic [LINE_WIDTH-1:0] LE  = {E3, E2, E1, E0};
  localparam logic [LINE_WIDTH-1:0] Z   = '0;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    read_i    = 1'b0;
    write_i   = 1'b0;
    resp_i    = 1'b0;
    burst_i   = '0;
    address_i = '0;
    line_i    = '0;

    // Reset state
    vecs.push_back(mk(1,0,0,0, 0, 0, Z,   0,0,0, 32'h0, 1,0, 1,Z));

    // Read with no wait states; resp_o 5 cycles after the accepting edge's cycle
    vecs.push_back(mk(0,1,0,0, 0,  32'h1234, Z,  1,0,0, 32'h1220, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B1, 32'h1234, Z,  1,0,0, 32'h1220, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B2, 32'h1234, Z,  1,0,0, 32'h1220, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B3, 32'h1234, Z,  1,0,0, 32'h1220, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B4, 32'h1234, Z,  0,0,1, 32'h1220, 0,0, 1,LR1));
    vecs.push_back(mk(0,1,0,0, 0,  32'h1234, Z,  0,0,0, 32'h1220, 0,0, 1,LR1));
    vecs.push_back(mk(0,0,0,0, 0,  32'h1234, Z,  0,0,0, 32'h1220, 0,0, 1,LR1));

    // Write with gaps: resp_i 1,0,0,1,1,0,1
    vecs.push_back(mk(0,0,1,0, 0, 32'hABCF, LW, 0,1,0, 32'hABC0, 1,D0, 0,Z));
    vecs.push_back(mk(0,0,1,1, 0, 32'hABCF, LW, 0,1,0, 32'hABC0, 1,D1, 0,Z));
    vecs.push_back(mk(0,0,1,0, 0, 32'hABCF, LW, 0,1,0, 32'hABC0, 1,D1, 0,Z));
    vecs.push_back(mk(0,0,1,0, 0, 32'hABCF, LW, 0,1,0, 32'hABC0, 1,D1, 0,Z));
    vecs.push_back(mk(0,0,1,1, 0, 32'hABCF, LW, 0,1,0, 32'hABC0, 1,D2, 0,Z));
    vecs.push_back(mk(0,0,1,1, 0, 32'hABCF, LW, 0,1,0, 32'hABC0, 1,D3, 0,Z));
    vecs.push_back(mk(0,0,1,0, 0, 32'hABCF, LW, 0,1,0, 32'hABC0, 1,D3, 0,Z));
    vecs.push_back(mk(0,0,1,1, 0, 32'hABCF, LW, 0,0,1, 32'hABC0, 0,0,  1,LR1));
    vecs.push_back(mk(0,0,1,0, 0, 32'hABCF, LW, 0,0,0, 32'hABC0, 0,0,  1,LR1));
    vecs.push_back(mk(0,0,0,0, 0, 32'hABCF, LW, 0,0,0, 32'hABC0, 0,0,  1,LR1));

    // Simultaneous read and write: write wins, line_o untouched
    vecs.push_back(mk(0,1,1,0, 0, 32'h8000_003F, LE, 0,1,0, 32'h8000_0020, 1,E0, 1,LR1));
    vecs.push_back(mk(0,1,1,1, 0, 32'h8000_003F, LE, 0,1,0, 32'h8000_0020, 1,E1, 0,Z));
    vecs.push_back(mk(0,1,1,1, 0, 32'h8000_003F, LE, 0,1,0, 32'h8000_0020, 1,E2, 0,Z));
    vecs.push_back(mk(0,1,1,1, 0, 32'h8000_003F, LE, 0,1,0, 32'h8000_0020, 1,E3, 0,Z));
    vecs.push_back(mk(0,1,1,1, 0, 32'h8000_003F, LE, 0,0,1, 32'h8000_0020, 0,0,  1,LR1));
    vecs.push_back(mk(0,1,1,0, 0, 32'h8000_003F, LE, 0,0,0, 32'h8000_0020, 0,0,  1,LR1));
    vecs.push_back(mk(0,0,0,0, 0, 32'h8000_003F, LE, 0,0,0, 32'h8000_0020, 0,0,  1,LR1));

    // Reset after two read beats, then a fresh read completes
    vecs.push_back(mk(0,1,0,0, 0,  32'h40, Z, 1,0,0, 32'h40, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, BA, 32'h40, Z, 1,0,0, 32'h40, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, BB, 32'h40, Z, 1,0,0, 32'h40, 0,0, 0,Z));
    vecs.push_back(mk(1,1,0,1, BC, 32'h40, Z, 0,0,0, 32'h0,  1,0, 1,Z));
    vecs.push_back(mk(0,1,0,0, 0,  32'hFFFF_FFFF, Z, 1,0,0, 32'hFFFF_FFE0, 0,0, 1,Z));
    vecs.push_back(mk(0,1,0,1, B5, 32'hFFFF_FFFF, Z, 1,0,0, 32'hFFFF_FFE0, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B6, 32'hFFFF_FFFF, Z, 1,0,0, 32'hFFFF_FFE0, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B7, 32'hFFFF_FFFF, Z, 1,0,0, 32'hFFFF_FFE0, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B8, 32'hFFFF_FFFF, Z, 0,0,1, 32'hFFFF_FFE0, 0,0, 1,LRF));
    vecs.push_back(mk(0,1,0,0, 0,  32'hFFFF_FFFF, Z, 0,0,0, 32'hFFFF_FFE0, 0,0, 1,LRF));
    vecs.push_back(mk(0,0,0,0, 0,  32'hFFFF_FFFF, Z, 0,0,0, 32'hFFFF_FFE0, 0,0, 1,LRF));

    // Back-to-back: read, then a write seen on the first IDLE cycle
    vecs.push_back(mk(0,1,0,0, 0,  32'h100, Z,  1,0,0, 32'h100, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, B9, 32'h100, Z,  1,0,0, 32'h100, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, BA, 32'h100, Z,  1,0,0, 32'h100, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, BB, 32'h100, Z,  1,0,0, 32'h100, 0,0, 0,Z));
    vecs.push_back(mk(0,1,0,1, BC, 32'h100, Z,  0,0,1, 32'h100, 0,0, 1,LRB));
    vecs.push_back(mk(0,1,0,0, 0,  32'h100, Z,  0,0,0, 32'h100, 0,0, 1,LRB));
    vecs.push_back(mk(0,0,1,0, 0,  32'h204, LW, 0,1,0, 32'h200, 1,D0, 1,LRB));
    vecs.push_back(mk(0,0,1,1, 0,  32'h204, LW, 0,1,0, 32'h200, 1,D1, 0,Z));
    vecs.push_back(mk(0,0,1,1, 0,  32'h204, LW, 0,1,0, 32'h200, 1,D2, 0,Z));
    vecs.push_back(mk(0,0,1,1, 0,  32'h204, LW, 0,1,0, 32'h200, 1,D3, 0,Z));
    vecs.push_back(mk(0,0,1,1, 0,  32'h204, LW, 0,0,1, 32'h200, 0,0,  1,LRB));
    vecs.push_back(mk(0,0,1,0, 0,  32'h204, LW, 0,0,0, 32'h200, 0,0,  1,LRB));
    vecs.push_back(mk(0,0,0,0, 0,  32'h204, LW, 0,0,0, 32'h200, 0,0,  1,LRB));
    vecs.push_back(mk(0,0,0,1, B1, 32'h204, LW, 0,0,0, 32'h200, 0,0,  1,LRB));

    // Apply on the falling edge, check 1 time unit after the rising edge
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      read_i    = vecs[i].rd;
      write_i   = vecs[i].wr;
      resp_i    = vecs[i].rsp;
      burst_i   = vecs[i].bi;
      address_i = vecs[i].ai;
      line_i    = vecs[i].li;
      @(posedge clk);
      #1;
      chk("read_o",    i, LINE_WIDTH'(read_o),    LINE_WIDTH'(vecs[i].ro));
      chk("write_o",   i, LINE_WIDTH'(write_o),   LINE_WIDTH'(vecs[i].wo));
      chk("resp_o",    i, LINE_WIDTH'(resp_o),    LINE_WIDTH'(vecs[i].rso));
      chk("address_o", i, LINE_WIDTH'(address_o), LINE_WIDTH'(vecs[i].ea));
      if (vecs[i].cbo) chk("burst_o", i, LINE_WIDTH'(burst_o), LINE_WIDTH'(vecs[i].ebo));
      if (vecs[i].cl)  chk("line_o",  i, line_o, vecs[i].el);
    end

    // Hand sequence: resp_i pulses while idle must not start anything
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b1; burst_i = B9;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_resp_i_read_o",  -1, LINE_WIDTH'(read_o),  LINE_WIDTH'(1'b0));
      chk("idle_resp_i_resp_o",  -1, LINE_WIDTH'(resp_o),  LINE_WIDTH'(1'b0));
      chk("idle_resp_i_line_o",  -1, line_o, LRB);
    end
    resp_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
